bram_tdp_param: RTL and testbench
=================================

// Module: bram_tdp_param
// PURPOSE
//  Parametrised true-dual-port block RAM for Verilator builds; successor to the fixed 2Kx8 dual-port model.
//  Adds configurable width/depth, per-port write mode and byte enables, and deterministic same-address collision handling.
//  Adds a post-reset clear sweep with a ready flag, and an optional output register stage.
//  Used as line buffers and stencil storage behind the generated pipeline modules.
// PARAMETERS
//  DATA_W        8      word width in bits; multiple of 8
//  ADDR_W        11     address width; depth = 2**ADDR_W words
//  WRITE_MODE_A  0      port A write mode: 0 write_first, 1 read_first, 2 no_change
//  WRITE_MODE_B  0      port B write mode, same encoding
//  CLEAR_VALUE   0      word written to every location during the clear sweep
// PORTS
//  CLK         in   1           single clock, all logic on posedge
//  reset       in   1           synchronous, active-high
//  ready       out  1           1 once clear sweep done; ports ignored while 0
//  ena         in   1           port A enable
//  wea         in   DATA_W/8    port A byte write enables; any bit set = write
//  addra       in   ADDR_W      port A address
//  dina        in   DATA_W      port A write data
//  douta       out  DATA_W      port A read data
//  enb,web,addrb,dinb,doutb     port B, identical to A
//  collision   out  1           1-cycle pulse: both ports wrote the same address
// BEHAVIOUR
//  Shared words live in bram_tdp_pkg; those that tie to ports are listed under STRUCTURE.
//  Reset (sync): ready=0, douta=doutb=0, collision=0, clear counter=0, FSM -> CLEAR. Memory contents are not reset directly.
//  FSM CLEAR: each cycle writes CLEAR_VALUE to mem[cnt], then cnt++.
//   - At cnt==2**ADDR_W-1, write it, then go to RUN; ready=1 on the next cycle.
//   - Sweep therefore takes 2**ADDR_W cycles.
//   - reset asserted mid-sweep restarts at cnt=0.
//   - en/we on both ports are ignored; douta/doutb hold 0.
//  FSM RUN: stays until reset. Per port, on a cycle with en=1:
//   - read: dout <= mem[addr]; latency 1 cycle.
//   - write: only byte lanes whose we bit is set are updated.
//   - write_first: dout <= mem[addr] with the written lanes replaced by din.
//   - read_first: dout <= old mem[addr].
//   - no_change: dout holds its value on write cycles.
//   - en=0: dout holds; no write.
//  Cross-port, same cycle, same address:
//   - both write: port A lanes win where both we bits are set; lanes written by only one port take that port's data.
//   - collision=1 on the next cycle, else 0.
//   - one writes, one reads: the reading port returns old data, whatever its mode; no collision flag.
//  Different addresses: fully independent, no interaction.
//  Address range: full power-of-two range, so no out-of-range case exists.
// CONFIGURATION
//  BRAM_TDP_OUTREG_EN defined:
//   - extra register after douta/doutb; read latency 2.
//   - stage loads every cycle, reset to 0.
//   - collision is also delayed 1 cycle so it lines up with the data.
//  Undefined: latency 1, as above.
// STRUCTURE
//  Package bram_tdp_pkg holds:
//   - localparams WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2;
//   - FSM state typedef {CLEAR, RUN};
//   - function merge_bytes(old, new, be) returning the lane-merged word.
//  One sub-module bram_tdp_port: per-port dout register and mode mux. Instantiated twice.
//  Top level holds the memory array, the clear FSM and the collision arbitration.
// TESTING
//  1. Clear sweep, ADDR_W=4, CLEAR_VALUE=8'hA5:
//     reset 1 cycle -> ready rises exactly 16 cycles after reset drops; every read returns A5.
//  2. Write_first, DATA_W=16:
//     A writes 16'h1234 with wea=2'b01 to addr 3 holding 16'hFFFF -> douta=16'hFF34 next cycle.
//     Next read of addr 3 -> 16'hFF34.
//  3. Mode check: B read_first, addr 5 holds 8'h11, B writes 8'h22.
//     -> doutb=8'h11 that cycle+1, then 8'h22 on re-read.
//     Same with no_change -> doutb keeps its previous value.
//  4. Collision: A and B both write addr 7, A=8'hAA, B=8'hBB -> collision=1 for one cycle; mem[7]=AA.
//     DATA_W=16, wea=01, web=10 -> mem[7] gets high byte from B, low byte from A.
//  5. A writes 8'h55 to addr 9 while B reads addr 9 -> doutb=old value; no collision.
//  6. Reset asserted at cnt=8 during sweep -> ready stays 0; sweep restarts.
//     With BRAM_TDP_OUTREG_EN, repeat 2 -> data arrives 2 cycles after the request.

Source files
------------

// File: rtl/bram_tdp_pkg.sv
// Shared definitions for the parametrised true-dual-port block RAM:
// write-mode codes, the clear/run state type and the byte-lane merge helper.
package bram_tdp_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } bram_state_e;

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    for (int i = 0; i < MAX_BE_W; i++) begin
      res[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_tdp_if.sv
// Bus bundle for both ports of bram_tdp_param plus its ready and collision status.
// Handshake: a port request (en=1, optional we) is taken on every rising CLK edge
// where ready=1; there is no backpressure, and requests while ready=0 are dropped.
interface bram_tdp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);

  logic                ena;
  logic [DATA_W/8-1:0] wea;
  logic [ADDR_W-1:0]   addra;
  logic [DATA_W-1:0]   dina;
  logic [DATA_W-1:0]   douta;

  logic                enb;
  logic [DATA_W/8-1:0] web;
  logic [ADDR_W-1:0]   addrb;
  logic [DATA_W-1:0]   dinb;
  logic [DATA_W-1:0]   doutb;

  logic                ready;
  logic                collision;

  modport master (
    output ena, wea, addra, dina,
    output enb, web, addrb, dinb,
    input  douta, doutb, ready, collision
  );

  modport slave (
    input  ena, wea, addra, dina,
    input  enb, web, addrb, dinb,
    output douta, doutb, ready, collision
  );

endinterface

// File: rtl/bram_tdp_port.sv
// One RAM port's read-data register and write-mode mux.
// BRAM_TDP_OUTREG_EN adds a second always-loading output register (latency 2).
module bram_tdp_port
  import bram_tdp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MODE   = WM_WRITE_FIRST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active,
  input  logic                en,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W-1:0]   old_word,
  output logic [DATA_W-1:0]   dout
);

  logic              wr;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;

  assign wr     = |be;
  assign merged = DATA_W'(merge_bytes(MAX_DATA_W'(old_word), MAX_DATA_W'(din),
                                      MAX_BE_W'(be)));

  // old_word is the pre-edge contents, so a plain read always sees old data
  // even when the other port writes the same address this cycle.
  always_comb begin
    dout_d = dout_q;
    if (active && en) begin
      if (!wr) begin
        dout_d = old_word;
      end else if (MODE == WM_WRITE_FIRST) begin
        dout_d = merged;
      end else if (MODE == WM_READ_FIRST) begin
        dout_d = old_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

`ifdef BRAM_TDP_OUTREG_EN
  logic [DATA_W-1:0] dout_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r <= '0;
    end else begin
      dout_r <= dout_q;
    end
  end

  assign dout = dout_r;
`else
  assign dout = dout_q;
`endif

endmodule

// File: rtl/bram_tdp_param.sv
// Parametrised true-dual-port block RAM with post-reset clear sweep, byte enables,
// per-port write modes and same-address collision flag. Optional BRAM_TDP_OUTREG_EN.
module bram_tdp_param
  import bram_tdp_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 11,
  parameter int                WRITE_MODE_A = 0,
  parameter int                WRITE_MODE_B = 0,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
  input  logic        CLK,
  input  logic        reset,
  bram_tdp_if.slave   bus,
  output bram_state_e state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  bram_state_e       state;
  bram_state_e       state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              clr_we;
  logic              running;
  logic              ready_q;

  logic              a_wr;
  logic              b_wr;
  logic              same_addr;
  logic              coll_now;
  logic              coll_q;
  logic [DATA_W-1:0] old_a;
  logic [DATA_W-1:0] old_b;
  logic [DATA_W-1:0] new_a;
  logic [DATA_W-1:0] new_b;
  logic [DATA_W-1:0] new_ab;

  // ---------------- clear sweep FSM ----------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + ADDR_W'(1);
        if (&cnt) begin
          state_nxt = RUN;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  assign running   = (state == RUN);
  assign state_dbg = state;
  assign bus.ready = ready_q;

  // ---------------- write arbitration ----------------
  assign a_wr      = running && !reset && bus.ena && (|bus.wea);
  assign b_wr      = running && !reset && bus.enb && (|bus.web);
  assign same_addr = (bus.addra == bus.addrb);
  assign coll_now  = a_wr && b_wr && same_addr;

  assign old_a = mem[bus.addra];
  assign old_b = mem[bus.addrb];

  assign new_a  = DATA_W'(merge_bytes(MAX_DATA_W'(old_a), MAX_DATA_W'(bus.dina),
                                      MAX_BE_W'(bus.wea)));
  assign new_b  = DATA_W'(merge_bytes(MAX_DATA_W'(old_b), MAX_DATA_W'(bus.dinb),
                                      MAX_BE_W'(bus.web)));
  // Same-address double write: lay B's lanes down first, then A's on top.
  assign new_ab = DATA_W'(merge_bytes(MAX_DATA_W'(new_b), MAX_DATA_W'(bus.dina),
                                      MAX_BE_W'(bus.wea)));

  always_ff @(posedge CLK) begin
    if (clr_we && !reset) begin
      mem[cnt] <= CLEAR_VALUE;
    end else if (coll_now) begin
      mem[bus.addra] <= new_ab;
    end else begin
      if (a_wr) begin
        mem[bus.addra] <= new_a;
      end
      if (b_wr) begin
        mem[bus.addrb] <= new_b;
      end
    end
  end

  // ---------------- collision flag ----------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_now;
    end
  end

`ifdef BRAM_TDP_OUTREG_EN
  logic coll_r;

  // Delayed one more cycle so the flag lines up with the registered read data.
  always_ff @(posedge CLK) begin
    if (reset) begin
      coll_r <= 1'b0;
    end else begin
      coll_r <= coll_q;
    end
  end

  assign bus.collision = coll_r;
`else
  assign bus.collision = coll_q;
`endif

  // ---------------- read ports ----------------
  bram_tdp_port #(
    .DATA_W (DATA_W),
    .MODE   (WRITE_MODE_A)
  ) u_port_a (
    .clk      (CLK),
    .reset    (reset),
    .active   (running),
    .en       (bus.ena),
    .be       (bus.wea),
    .din      (bus.dina),
    .old_word (old_a),
    .dout     (bus.douta)
  );

  bram_tdp_port #(
    .DATA_W (DATA_W),
    .MODE   (WRITE_MODE_B)
  ) u_port_b (
    .clk      (CLK),
    .reset    (reset),
    .active   (running),
    .en       (bus.enb),
    .be       (bus.web),
    .din      (bus.dinb),
    .old_word (old_b),
    .dout     (bus.doutb)
  );

endmodule

// File: tb/tb_bram_tdp_param.sv
// Bench for bram_tdp_param: three 16x16 instances covering every write mode on
// each port, all driven by the same stimulus and checked against an array model.
module tb_bram_tdp_param;
  import bram_tdp_pkg::*;

  localparam int N     = 3;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [15:0] CLR = 16'hA5A5;
  localparam int MODE_A [N] = '{0, 1, 2};
  localparam int MODE_B [N] = '{1, 2, 0};
`ifdef BRAM_TDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          ena = 1'b0, enb = 1'b0;
  logic [1:0]    wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [15:0]   dina = '0, dinb = '0;

  logic [15:0] douta_o [N];
  logic [15:0] doutb_o [N];
  logic        ready_o [N];
  logic        coll_o  [N];
  bram_state_e st_o    [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    bram_tdp_if #(.DATA_W(16), .ADDR_W(AW)) bus ();
    assign bus.ena   = ena;
    assign bus.wea   = wea;
    assign bus.addra = addra;
    assign bus.dina  = dina;
    assign bus.enb   = enb;
    assign bus.web   = web;
    assign bus.addrb = addrb;
    assign bus.dinb  = dinb;
    assign douta_o[g] = bus.douta;
    assign doutb_o[g] = bus.doutb;
    assign ready_o[g] = bus.ready;
    assign coll_o[g]  = bus.collision;

    bram_tdp_param #(
      .DATA_W       (16),
      .ADDR_W       (AW),
      .WRITE_MODE_A (MODE_A[g]),
      .WRITE_MODE_B (MODE_B[g]),
      .CLEAR_VALUE  (CLR)
    ) u_dut (
      .CLK       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (st_o[g])
    );
  end

  // ---------------- reference model ----------------
  logic [15:0] m   [N][DEPTH];
  logic [15:0] s1a [N], s1b [N], s2a [N], s2b [N];
  logic        c1  [N], c2  [N];
  int          clr_left = DEPTH;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [15:0] lanes(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] be);
    return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction

  function automatic logic [15:0] ea(input int i);
    if (LAT == 2) return s2a[i];
    return s1a[i];
  endfunction

  function automatic logic [15:0] eb(input int i);
    if (LAT == 2) return s2b[i];
    return s1b[i];
  endfunction

  function automatic logic ec(input int i);
    if (LAT == 2) return c2[i];
    return c1[i];
  endfunction

  task automatic model_step();
    logic [15:0] oa, ob;
    logic        a_wr, b_wr;
    for (int i = 0; i < N; i++) begin
      s2a[i] = s1a[i];
      s2b[i] = s1b[i];
      c2[i]  = c1[i];
      if (reset) begin
        s1a[i] = '0; s1b[i] = '0; s2a[i] = '0; s2b[i] = '0;
        c1[i]  = 1'b0; c2[i] = 1'b0;
      end else if (clr_left > 0) begin
        c1[i] = 1'b0;
      end else begin
        oa   = m[i][addra];
        ob   = m[i][addrb];
        a_wr = ena && (wea != 2'b00);
        b_wr = enb && (web != 2'b00);
        if (ena) begin
          if (!a_wr)              s1a[i] = oa;
          else if (MODE_A[i] == 0) s1a[i] = lanes(oa, dina, wea);
          else if (MODE_A[i] == 1) s1a[i] = oa;
        end
        if (enb) begin
          if (!b_wr)              s1b[i] = ob;
          else if (MODE_B[i] == 0) s1b[i] = lanes(ob, dinb, web);
          else if (MODE_B[i] == 1) s1b[i] = ob;
        end
        if (b_wr) m[i][addrb] = lanes(ob, dinb, web);
        if (a_wr) m[i][addra] = lanes(m[i][addra], dina, wea);
        c1[i] = a_wr && b_wr && (addra == addrb);
      end
    end
    if (reset) begin
      clr_left = DEPTH;
    end else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) begin
        for (int i = 0; i < N; i++)
          for (int a = 0; a < DEPTH; a++) m[i][a] = CLR;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  task automatic drive_random(input bit narrow);
    int amax;
    amax  = narrow ? 3 : DEPTH - 1;
    ena   = 1'($urandom_range(0, 1));
    enb   = 1'($urandom_range(0, 1));
    wea   = 2'($urandom_range(0, 3));
    web   = 2'($urandom_range(0, 3));
    addra = AW'($urandom_range(0, amax));
    addrb = AW'($urandom_range(0, amax));
    dina  = 16'($urandom);
    dinb  = 16'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_random(1'b0);
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      total++;
      if (ready_o[i] !== 1'b0 || douta_o[i] !== 16'h0 || doutb_o[i] !== 16'h0 ||
          coll_o[i] !== 1'b0 || st_o[i] !== CLEAR) begin
        bad++;
        $display("FAIL reset_state inst=%0d got rdy=%b a=%h b=%h col=%b st=%0d exp 0/0/0/0/CLEAR",
                 i, ready_o[i], douta_o[i], doutb_o[i], coll_o[i], st_o[i]);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      drive_random(1'b0);
      tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (ready_o[i] !== (k == DEPTH) || douta_o[i] !== ea(i) || doutb_o[i] !== eb(i)) begin
          bad++;
          $display("FAIL sweep_ready inst=%0d k=%0d got rdy=%b a=%h b=%h exp rdy=%b a=%h b=%h",
                   i, k, ready_o[i], douta_o[i], doutb_o[i], (k == DEPTH), ea(i), eb(i));
        end
      end
    end
    idle();
    for (int i = 0; i < N; i++) begin
      total++;
      if (st_o[i] !== RUN) begin
        bad++;
        $display("FAIL sweep_state inst=%0d got=%0d exp=RUN", i, st_o[i]);
      end
    end
  endtask

  task automatic test_clear_read(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      ena = 1'b1; wea = '0; addra = AW'(k);
      enb = 1'b1; web = '0; addrb = AW'(DEPTH - 1 - k);
      tick();
      idle();
      repeat (LAT - 1) tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (douta_o[i] !== CLR || doutb_o[i] !== CLR) begin
          bad++;
          $display("FAIL %s inst=%0d addr=%0d got a=%h b=%h exp=%h",
                   tag, i, k, douta_o[i], doutb_o[i], CLR);
        end
      end
    end
  endtask

  task automatic test_write_first();
    ena = 1'b1; wea = 2'b11; addra = 4'd3; dina = 16'hFFFF;
    tick();
    wea = 2'b01; dina = 16'h1234;
    tick();
    idle();
    repeat (LAT - 1) tick();
    total++;
    if (douta_o[0] !== 16'hFF34) begin
      bad++;
      $display("FAIL wf_douta got=%h exp=%h", douta_o[0], 16'hFF34);
    end
    for (int i = 1; i < N; i++) begin
      total++;
      if (douta_o[i] !== ea(i)) begin
        bad++;
        $display("FAIL wf_other_modes inst=%0d got=%h exp=%h", i, douta_o[i], ea(i));
      end
    end
    ena = 1'b1; wea = '0; addra = 4'd3;
    tick();
    idle();
    repeat (LAT - 1) tick();
    for (int i = 0; i < N; i++) begin
      total++;
      if (douta_o[i] !== 16'hFF34) begin
        bad++;
        $display("FAIL wf_reread inst=%0d got=%h exp=%h", i, douta_o[i], 16'hFF34);
      end
    end
  endtask

  task automatic test_modes();
    enb = 1'b1; web = 2'b11; addrb = 4'd5; dinb = 16'h0011;
    tick();
    dinb = 16'h0022;
    tick();
    idle();
    repeat (LAT - 1) tick();
    total++;
    if (doutb_o[0] !== 16'h0011) begin
      bad++;
      $display("FAIL rf_doutb got=%h exp=%h", doutb_o[0], 16'h0011);
    end
    total++;
    if (doutb_o[1] !== CLR || doutb_o[1] !== eb(1)) begin
      bad++;
      $display("FAIL nc_doutb got=%h exp=%h", doutb_o[1], CLR);
    end
    total++;
    if (doutb_o[2] !== 16'h0022) begin
      bad++;
      $display("FAIL wfb_doutb got=%h exp=%h", doutb_o[2], 16'h0022);
    end
    enb = 1'b1; web = '0; addrb = 4'd5;
    tick();
    idle();
    repeat (LAT - 1) tick();
    for (int i = 0; i < N; i++) begin
      total++;
      if (doutb_o[i] !== 16'h0022) begin
        bad++;
        $display("FAIL mode_reread inst=%0d got=%h exp=%h", i, doutb_o[i], 16'h0022);
      end
    end
  endtask

  task automatic test_collision();
    logic [1:0]  bea [2];
    logic [1:0]  beb [2];
    logic [15:0] exp_w [2];
    bea = '{2'b11, 2'b01}; beb = '{2'b11, 2'b10}; exp_w = '{16'h00AA, 16'h2211};
    for (int t = 0; t < 2; t++) begin
      ena = 1'b1; enb = 1'b1; addra = 4'd7; addrb = 4'd7;
      wea = bea[t]; web = beb[t];
      dina = (t == 0) ? 16'h00AA : 16'h1111;
      dinb = (t == 0) ? 16'h00BB : 16'h2222;
      tick();
      idle();
      repeat (LAT - 1) tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (coll_o[i] !== 1'b1) begin
          bad++;
          $display("FAIL coll_pulse t=%0d inst=%0d got=%b exp=1", t, i, coll_o[i]);
        end
      end
      tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (coll_o[i] !== 1'b0) begin
          bad++;
          $display("FAIL coll_clear t=%0d inst=%0d got=%b exp=0", t, i, coll_o[i]);
        end
      end
      ena = 1'b1; wea = '0; addra = 4'd7;
      tick();
      idle();
      repeat (LAT - 1) tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (douta_o[i] !== exp_w[t]) begin
          bad++;
          $display("FAIL coll_data t=%0d inst=%0d got=%h exp=%h", t, i, douta_o[i], exp_w[t]);
        end
      end
    end
  endtask

  task automatic test_read_during_write();
    ena = 1'b1; wea = 2'b11; addra = 4'd9; dina = 16'h0077;
    tick();
    dina = 16'h0055;
    enb = 1'b1; web = '0; addrb = 4'd9;
    tick();
    idle();
    repeat (LAT - 1) tick();
    for (int i = 0; i < N; i++) begin
      total++;
      if (doutb_o[i] !== 16'h0077 || coll_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL rdw_old inst=%0d got b=%h col=%b exp b=%h col=0",
                 i, doutb_o[i], coll_o[i], 16'h0077);
      end
    end
    enb = 1'b1; addrb = 4'd9;
    tick();
    idle();
    repeat (LAT - 1) tick();
    for (int i = 0; i < N; i++) begin
      total++;
      if (doutb_o[i] !== 16'h0055) begin
        bad++;
        $display("FAIL rdw_new inst=%0d got=%h exp=%h", i, doutb_o[i], 16'h0055);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_random(1'($urandom_range(0, 1)));
      tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (douta_o[i] !== ea(i) || doutb_o[i] !== eb(i) || coll_o[i] !== ec(i) ||
            ready_o[i] !== 1'b1) begin
          bad++;
          $display("FAIL rand c=%0d inst=%0d got a=%h b=%h col=%b rdy=%b exp a=%h b=%h col=%b rdy=1",
                   c, i, douta_o[i], doutb_o[i], coll_o[i], ready_o[i], ea(i), eb(i), ec(i));
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (8) begin
      drive_random(1'b0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      drive_random(1'b0);
      tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (ready_o[i] !== (k == DEPTH) || douta_o[i] !== 16'h0) begin
          bad++;
          $display("FAIL mid_sweep_ready inst=%0d k=%0d got rdy=%b a=%h exp rdy=%b a=0000",
                   i, k, ready_o[i], douta_o[i], (k == DEPTH));
        end
      end
    end
    idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clear_read("clear_read");
    test_write_first();
    test_modes();
    test_collision();
    test_read_during_write();
    test_random();
    test_reset_mid_sweep();
    test_clear_read("clear_after_restart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
